// File: rtl/vram_scroll_if.sv
// Bundle of the command handshake, CPU port and video RAM port of vram_scroll_engine.
// The slave modport is the engine's view; master is the CPU/RAM side.
interface vram_scroll_if #(
    parameter int ADDR_W = 11
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [7:0]        fill_char;
    logic              done;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_wait;
    logic              rd_ram1;
    logic              wr_ram1;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [7:0]        ram1_out;

    modport slave (
        input  cmd_valid, cmd_op, fill_char, cpu_rd, cpu_wr, cpu_addr, cpu_wdata, ram1_out,
        output cmd_ready, done, cpu_rdata, cpu_wait, rd_ram1, wr_ram1, addr, data
    );

    modport master (
        output cmd_valid, cmd_op, fill_char, cpu_rd, cpu_wr, cpu_addr, cpu_wdata, ram1_out,
        input  cmd_ready, done, cpu_rdata, cpu_wait, rd_ram1, wr_ram1, addr, data
    );
endinterface

// File: rtl/vram_scroll_engine.sv
// Video RAM CPU-port owner: passes CPU accesses through when idle, and autonomously
// clears the text page or scrolls it one row up/down while stalling the CPU.
module vram_scroll_engine #(
    parameter int COLS   = 32,
    parameter int ROWS   = 16,
    parameter int ADDR_W = 11
) (
    input  logic           clk,
    input  logic           resetn,
    vram_scroll_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCR_RD = 3'd1,
        SCR_WR = 3'd2,
        FILL   = 3'd3,
        CLR    = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_SRC  = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] PAGE_LAST = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] COL_MASK  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] IDX_ZERO  = '0;
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_next_idx;
    logic [7:0]        r_fill;
    logic              r_down;
    logic              r_done;
    logic              w_accept;

    logic              w_rd;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_data;

    assign w_accept = (r_state == IDLE) && bus.cmd_valid;

    // Next-state and index sequencing for clear / scroll / fill passes
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        2'b00: begin w_next_state = CLR;    w_next_idx = IDX_ZERO; end
                        2'b01: begin w_next_state = SCR_RD; w_next_idx = IDX_ZERO; end
                        2'b10: begin w_next_state = SCR_RD; w_next_idx = LAST_SRC; end
                        default: begin w_next_state = FIN;  w_next_idx = IDX_ZERO; end
                    endcase
                end else begin
                    w_next_state = IDLE;
                end
            end
            SCR_RD: w_next_state = SCR_WR;
            SCR_WR: begin
                // Downward scroll walks backwards so no source cell is overwritten before it is read
                if (r_down) begin
                    if (r_idx == IDX_ZERO) begin
                        w_next_state = FILL;
                        w_next_idx   = IDX_ZERO;
                    end else begin
                        w_next_state = SCR_RD;
                        w_next_idx   = r_idx - IDX_ONE;
                    end
                end else begin
                    w_next_idx = r_idx + IDX_ONE;
                    if (r_idx == LAST_SRC) begin
                        w_next_state = FILL;
                    end else begin
                        w_next_state = SCR_RD;
                    end
                end
            end
            FILL: begin
                if ((r_idx & COL_MASK) == COL_MASK) begin
                    w_next_state = FIN;
                    w_next_idx   = IDX_ZERO;
                end else begin
                    w_next_idx   = r_idx + IDX_ONE;
                end
            end
            CLR: begin
                if (r_idx == PAGE_LAST) begin
                    w_next_state = FIN;
                    w_next_idx   = IDX_ZERO;
                end else begin
                    w_next_idx   = r_idx + IDX_ONE;
                end
            end
            FIN:     w_next_state = IDLE;
            default: begin w_next_state = IDLE; w_next_idx = IDX_ZERO; end
        endcase
    end

    // State, index, latched command parameters and done pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_fill  <= 8'h00;
            r_down  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_done  <= (w_next_state == FIN);
            if (w_accept) begin
                r_fill <= bus.fill_char;
                r_down <= (bus.cmd_op == 2'b10);
            end else begin
                r_fill <= r_fill;
                r_down <= r_down;
            end
        end
    end

    // RAM port decode: CPU passthrough when idle, engine access otherwise
    always_comb begin
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_addr = '0;
        w_data = 8'h00;
        case (r_state)
            IDLE: begin
                w_rd   = bus.cpu_rd;
                w_wr   = bus.cpu_wr;
                w_addr = bus.cpu_addr;
                w_data = bus.cpu_wdata;
            end
            SCR_RD: begin
                w_rd   = 1'b1;
                w_addr = r_down ? r_idx : (r_idx + COLS_A);
            end
            SCR_WR: begin
                w_wr   = 1'b1;
                w_addr = r_down ? (r_idx + COLS_A) : r_idx;
                w_data = bus.ram1_out;
            end
            FILL, CLR: begin
                w_wr   = 1'b1;
                w_addr = r_idx;
                w_data = r_fill;
            end
            default: begin
                w_rd = 1'b0;
                w_wr = 1'b0;
            end
        endcase
    end

    assign bus.rd_ram1   = w_rd;
    assign bus.wr_ram1   = w_wr;
    assign bus.addr      = w_addr;
    assign bus.data      = w_data;
    assign bus.cpu_rdata = bus.ram1_out;
    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.cpu_wait  = (r_state != IDLE);
    assign bus.done      = r_done;

endmodule

// File: tb/tb_vram_scroll_engine.sv
// Bench for vram_scroll_engine: behavioural video RAM, page-level reference model of
// clear/scroll results and busy lengths, and a monitor on engine RAM accesses.
module tb_vram_scroll_engine;
    localparam int ADDR_W = 11;
    localparam int MEMSZ  = 2048;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_fail;
    int   viol;

    logic [7:0] mem  [0:MEMSZ-1];
    logic [7:0] pre  [0:MEMSZ-1];
    logic [7:0] expv [0:MEMSZ-1];
    logic [7:0] ram_q;

    vram_scroll_if #(.ADDR_W(ADDR_W)) bus_if ();

    vram_scroll_engine #(.COLS(32), .ROWS(16), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read video RAM with a monitor on accesses made while the engine owns the port
    always @(posedge clk) begin
        if (bus_if.wr_ram1) mem[bus_if.addr] <= bus_if.data;
        if (bus_if.rd_ram1) ram_q <= mem[bus_if.addr];
        if (resetn && bus_if.cpu_wait) begin
            if (bus_if.rd_ram1 && bus_if.wr_ram1) viol <= viol + 1;
            if ((bus_if.rd_ram1 || bus_if.wr_ram1) && (bus_if.addr > 11'd511)) viol <= viol + 1;
        end
    end
    assign bus_if.ram1_out = ram_q;

    function automatic int exp_latency(input logic [1:0] op);
        if (op == 2'b00) return 16 * 32 + 1;
        if (op == 2'b11) return 1;
        return 2 * 15 * 32 + 32 + 1;
    endfunction

    // Expected page image after a command, from the row-level meaning of each op
    function automatic void model(input logic [1:0] op, input logic [7:0] fill);
        for (int a = 0; a < MEMSZ; a++) expv[a] = pre[a];
        for (int a = 0; a < 512; a++) begin
            case (op)
                2'b00: expv[a] = fill;
                2'b01: expv[a] = (a / 32 == 15) ? fill : pre[a + 32];
                2'b10: expv[a] = (a / 32 == 0) ? fill : pre[a - 32];
                default: expv[a] = pre[a];
            endcase
        end
    endfunction

    function automatic int count_diff(output int first);
        int n;
        n = 0;
        first = -1;
        for (int a = 0; a < MEMSZ; a++) begin
            if (mem[a] !== expv[a]) begin
                if (first < 0) first = a;
                n++;
            end
        end
        return n;
    endfunction

    task automatic preload(input bit row_pattern);
        @(negedge clk);
        bus_if.cpu_wr = 1'b1;
        for (int a = 0; a < 512 + 3; a++) begin
            if (a < 512) begin
                bus_if.cpu_addr  = 11'(a);
                bus_if.cpu_wdata = row_pattern ? 8'(a / 32) : 8'($urandom);
            end else begin
                bus_if.cpu_addr  = (a == 512) ? 11'h200 : ((a == 513) ? 11'h300 : 11'h7FF);
                bus_if.cpu_wdata = 8'($urandom);
            end
            @(negedge clk);
        end
        bus_if.cpu_wr = 1'b0;
        @(negedge clk);
        for (int a = 0; a < MEMSZ; a++) pre[a] = mem[a];
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] fill,
                           output int lat, output logic pulse1);
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = op;
        bus_if.fill_char = fill;
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        bus_if.fill_char = 8'($urandom);
        lat = 0;
        pulse1 = 1'b0;
        while (lat < 3000) begin
            @(negedge clk);
            lat++;
            if (bus_if.done === 1'b1) break;
        end
        @(negedge clk);
        pulse1 = (bus_if.done === 1'b0);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        bus_if.cmd_valid = 1'b0; bus_if.cmd_op = 2'b00; bus_if.fill_char = 8'h00;
        bus_if.cpu_rd = 1'b0; bus_if.cpu_wr = 1'b0; bus_if.cpu_addr = '0; bus_if.cpu_wdata = 8'h00;
        #23;
        n_cmp++;
        if ({bus_if.cmd_ready, bus_if.cpu_wait, bus_if.done, bus_if.rd_ram1, bus_if.wr_ram1} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 10000",
                     {bus_if.cmd_ready, bus_if.cpu_wait, bus_if.done, bus_if.rd_ram1, bus_if.wr_ram1});
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_cpu_passthrough;
        logic [10:0] a;
        logic [7:0]  d;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 11'h005 : 11'($urandom_range(0, MEMSZ - 1));
            d = (i == 0) ? 8'h41 : 8'($urandom);
            @(negedge clk);
            bus_if.cpu_wr = 1'b1; bus_if.cpu_addr = a; bus_if.cpu_wdata = d;
            #1;
            n_cmp++;
            if ({bus_if.wr_ram1, bus_if.rd_ram1, bus_if.addr, bus_if.data, bus_if.cpu_wait} !== {1'b1, 1'b0, a, d, 1'b0}) begin
                n_fail++;
                $display("FAIL cpu_wr_mirror: got wr=%b rd=%b addr=%h data=%h wait=%b expected wr=1 rd=0 addr=%h data=%h wait=0",
                         bus_if.wr_ram1, bus_if.rd_ram1, bus_if.addr, bus_if.data, bus_if.cpu_wait, a, d);
            end
            @(negedge clk);
            bus_if.cpu_wr = 1'b0; bus_if.cpu_rd = 1'b1;
            #1;
            n_cmp++;
            if ({bus_if.rd_ram1, bus_if.wr_ram1, bus_if.addr} !== {1'b1, 1'b0, a}) begin
                n_fail++;
                $display("FAIL cpu_rd_mirror: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=%h",
                         bus_if.rd_ram1, bus_if.wr_ram1, bus_if.addr, a);
            end
            @(negedge clk);
            bus_if.cpu_rd = 1'b0;
            n_cmp++;
            if (bus_if.cpu_rdata !== d) begin
                n_fail++;
                $display("FAIL cpu_rdata: got %h expected %h", bus_if.cpu_rdata, d);
            end
        end
    endtask

    task automatic check_cmd(input string name, input logic [1:0] op, input logic [7:0] fill,
                             input int lat, input logic pulse1);
        int nd;
        int first;
        model(op, fill);
        nd = count_diff(first);
        n_cmp++;
        if (lat !== exp_latency(op)) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_latency(op));
        end
        n_cmp++;
        if (pulse1 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_width: done still high after one cycle, expected single-cycle pulse", name);
        end
        n_cmp++;
        if (nd !== 0) begin
            n_fail++;
            $display("FAIL %s_image: %0d cells differ, first at %h got %h expected %h",
                     name, nd, first, mem[first], expv[first]);
        end
        n_cmp++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL %s_port_rules: got %0d illegal engine accesses expected 0", name, viol);
        end
    endtask

    task automatic test_scroll_up;
        int lat;
        logic p;
        preload(1'b1);
        run_cmd(2'b01, 8'h20, lat, p);
        check_cmd("scroll_up", 2'b01, 8'h20, lat, p);
    endtask

    task automatic test_scroll_down;
        int lat;
        logic p;
        preload(1'b1);
        run_cmd(2'b10, 8'h2E, lat, p);
        check_cmd("scroll_down", 2'b10, 8'h2E, lat, p);
    endtask

    task automatic test_clear;
        int lat;
        logic p;
        preload(1'b0);
        run_cmd(2'b00, 8'h00, lat, p);
        check_cmd("clear", 2'b00, 8'h00, lat, p);
    endtask

    task automatic test_random_ops;
        int lat;
        logic p;
        logic [1:0] op;
        logic [7:0] f;
        for (int i = 0; i < 4; i++) begin
            op = (i == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            f  = 8'($urandom);
            preload(1'b0);
            run_cmd(op, f, lat, p);
            check_cmd("random_op", op, f, lat, p);
        end
    endtask

    task automatic test_cpu_stall;
        int lat;
        int nd;
        int first;
        preload(1'b0);
        @(negedge clk);
        bus_if.cmd_valid = 1'b1; bus_if.cmd_op = 2'b01; bus_if.fill_char = 8'h55;
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        bus_if.cpu_wr = 1'b1; bus_if.cpu_addr = 11'h300; bus_if.cpu_wdata = 8'h5A;
        #1;
        n_cmp++;
        if ({bus_if.cpu_wait, bus_if.cmd_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_wait: got wait/ready=%b expected 10", {bus_if.cpu_wait, bus_if.cmd_ready});
        end
        while (lat < 3000 && bus_if.done !== 1'b1) begin
            @(negedge clk);
            lat++;
            // A clear request raised while busy must be ignored, not queued
            bus_if.cmd_op    = 2'b00;
            bus_if.cmd_valid = (lat >= 20 && lat < 30);
        end
        bus_if.cmd_valid = 1'b0;
        n_cmp++;
        if (lat !== exp_latency(2'b01)) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d expected %0d", lat, exp_latency(2'b01));
        end
        @(negedge clk);
        n_cmp++;
        if ({bus_if.cpu_wait, mem[11'h300]} !== {1'b0, pre[11'h300]}) begin
            n_fail++;
            $display("FAIL stall_held_write: got wait=%b mem300=%h expected wait=0 mem300=%h",
                     bus_if.cpu_wait, mem[11'h300], pre[11'h300]);
        end
        @(negedge clk);
        bus_if.cpu_wr = 1'b0;
        model(2'b01, 8'h55);
        expv[11'h300] = 8'h5A;
        nd = count_diff(first);
        n_cmp++;
        if (nd !== 0) begin
            n_fail++;
            $display("FAIL stall_image: %0d cells differ, first at %h got %h expected %h",
                     nd, first, mem[first], expv[first]);
        end
        n_cmp++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL stall_port_rules: got %0d illegal engine accesses expected 0", viol);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic p;
        preload(1'b0);
        @(negedge clk);
        bus_if.cmd_valid = 1'b1; bus_if.cmd_op = 2'b10; bus_if.fill_char = 8'h77;
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        repeat (300) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({bus_if.rd_ram1, bus_if.wr_ram1, bus_if.cmd_ready, bus_if.cpu_wait, bus_if.done} !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 00100",
                     {bus_if.rd_ram1, bus_if.wr_ram1, bus_if.cmd_ready, bus_if.cpu_wait, bus_if.done});
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int a = 0; a < MEMSZ; a++) pre[a] = mem[a];
        run_cmd(2'b00, 8'h3C, lat, p);
        check_cmd("reset_then_clear", 2'b00, 8'h3C, lat, p);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        viol   = 0;
        ram_q  = 8'h00;
        test_reset();
        test_cpu_passthrough();
        test_scroll_up();
        test_scroll_down();
        test_clear();
        test_cpu_stall();
        test_random_ops();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
